// File: rtl/types_pkg.sv
// Shared types for the reorder buffer: FU completion buses, ROB entry layout and sizing.
package types_pkg;

    localparam int ROB_DEPTH = 32;
    localparam int ROB_TAG_W = 5;
    localparam int PREG_W    = 7;

    typedef struct packed {
        logic                 fu_alu_done;
        logic [ROB_TAG_W-1:0] rob_fu_alu;
    } alu_data;

    typedef struct packed {
        logic                 fu_mem_done;
        logic [ROB_TAG_W-1:0] rob_fu_mem;
    } mem_data;

    typedef struct packed {
        logic                 fu_b_done;
        logic [ROB_TAG_W-1:0] rob_fu_b;
        logic                 mispredict;
        logic [ROB_TAG_W-1:0] mispredict_tag;
    } b_data;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] rob_index;
        logic                 valid;
        logic                 complete;
        logic [PREG_W-1:0]    pd_new;
        logic [PREG_W-1:0]    pd_old;
        logic [31:0]          pc;
    } rob_data;

endpackage

// File: rtl/rob_perf_counters.sv
// Saturating event counters for the reorder buffer; only instantiated when ROB_PERF_CNT_EN is defined.
module rob_perf_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit,
    input  logic        full,
    input  logic        flush,
    output logic [31:0] perf_commits,
    output logic [31:0] perf_full_cycles,
    output logic [15:0] perf_flushes
);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_commits     <= '0;
            perf_full_cycles <= '0;
            perf_flushes     <= '0;
        end else begin
            if (commit && perf_commits != '1)
                perf_commits <= perf_commits + 32'd1;
            if (full && perf_full_cycles != '1)
                perf_full_cycles <= perf_full_cycles + 32'd1;
            if (flush && perf_flushes != '1)
                perf_flushes <= perf_flushes + 16'd1;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer with mispredict squash of younger entries.
// Optional saturating performance counters are added when ROB_PERF_CNT_EN is defined.
module reorder_buffer
    import types_pkg::*;
#(
    parameter int  DEPTH = ROB_DEPTH,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [PREG_W-1:0] disp_pd_new,
    input  logic [PREG_W-1:0] disp_pd_old,
    input  logic [31:0]       disp_pc,
    output logic [TAG_W-1:0]  disp_tag,
    input  alu_data           alu_in,
    input  mem_data           mem_in,
    input  b_data             br_in,
    output logic              commit_valid,
    output logic [PREG_W-1:0] commit_pd_old,
    output logic [PREG_W-1:0] commit_pd_new,
    output logic [31:0]       commit_pc,
    output logic [TAG_W-1:0]  commit_tag,
    output logic              rob_empty,
    output logic [TAG_W-1:0]  head_tag
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_commits,
    output logic [31:0]       perf_full_cycles,
    output logic [15:0]       perf_flushes
`endif
);

    localparam int CNT_W = TAG_W + 1;

    rob_data           entries [DEPTH];
    logic [TAG_W-1:0]  head, tail, head_next;
    logic [CNT_W-1:0]  count;
    logic [TAG_W-1:0]  br_tag, squash_pos, flush_dist, rel;
    logic [DEPTH-1:0]  squash;
    logic              fire, commit, mispredict;

    assign mispredict = br_in.mispredict;
    assign br_tag     = br_in.mispredict_tag;
    assign disp_ready = (count < CNT_W'(DEPTH));
    assign fire       = disp_valid & disp_ready & ~mispredict;
    assign commit     = entries[head].valid & entries[head].complete;
    assign head_next  = commit ? head + 1'b1 : head;
    assign squash_pos = br_tag - head;
    assign flush_dist = br_tag - head_next;

    assign disp_tag      = tail;
    assign commit_valid  = commit;
    assign commit_pd_old = commit ? entries[head].pd_old : '0;
    assign commit_pd_new = commit ? entries[head].pd_new : '0;
    assign commit_pc     = commit ? entries[head].pc : '0;
    assign commit_tag    = commit ? entries[head].rob_index : '0;
    assign rob_empty     = (count == '0);
    assign head_tag      = head;

    // Younger-than-branch test is done in head-relative order so a full ROB is handled correctly.
    always_comb begin
        squash = '0;
        rel    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel       = TAG_W'(i) - head;
            squash[i] = mispredict && (rel > squash_pos) && ({1'b0, rel} < count);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head <= head_next;
            if (mispredict) begin
                tail  <= br_tag + 1'b1;
                count <= {1'b0, flush_dist} + 1'b1;
            end else begin
                if (fire)
                    tail <= tail + 1'b1;
                count <= count + CNT_W'(fire) - CNT_W'(commit);
            end
        end
    end

    // Squash is applied after the completion writes so a same-cycle completion to a squashed slot loses.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i]           <= '0;
                entries[i].rob_index <= TAG_W'(i);
            end
        end else begin
            if (alu_in.fu_alu_done && entries[alu_in.rob_fu_alu].valid)
                entries[alu_in.rob_fu_alu].complete <= 1'b1;
            if (mem_in.fu_mem_done && entries[mem_in.rob_fu_mem].valid)
                entries[mem_in.rob_fu_mem].complete <= 1'b1;
            if (br_in.fu_b_done && entries[br_in.rob_fu_b].valid)
                entries[br_in.rob_fu_b].complete <= 1'b1;
            if (commit)
                entries[head].valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (squash[i]) begin
                    entries[i].valid    <= 1'b0;
                    entries[i].complete <= 1'b0;
                end
            end
            if (fire) begin
                entries[tail].rob_index <= tail;
                entries[tail].valid     <= 1'b1;
                entries[tail].complete  <= 1'b0;
                entries[tail].pd_new    <= disp_pd_new;
                entries[tail].pd_old    <= disp_pd_old;
                entries[tail].pc        <= disp_pc;
            end
        end
    end

`ifdef ROB_PERF_CNT_EN
    rob_perf_counters u_perf (
        .clk              (clk),
        .reset            (reset),
        .commit           (commit),
        .full             (count == CNT_W'(DEPTH)),
        .flush            (mispredict),
        .perf_commits     (perf_commits),
        .perf_full_cycles (perf_full_cycles),
        .perf_flushes     (perf_flushes)
    );
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: dispatch, completion, commit, wrap and mispredict squash.
module tb_reorder_buffer;
    import types_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_valid;
    logic        disp_ready;
    logic [6:0]  disp_pd_new, disp_pd_old;
    logic [31:0] disp_pc;
    logic [4:0]  disp_tag;
    alu_data     alu_in;
    mem_data     mem_in;
    b_data       br_in;
    logic        commit_valid;
    logic [6:0]  commit_pd_old, commit_pd_new;
    logic [31:0] commit_pc;
    logic [4:0]  commit_tag;
    logic        rob_empty;
    logic [4:0]  head_tag;
`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_commits, perf_full_cycles;
    logic [15:0] perf_flushes;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk           (clk),
        .reset         (reset),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_pd_new   (disp_pd_new),
        .disp_pd_old   (disp_pd_old),
        .disp_pc       (disp_pc),
        .disp_tag      (disp_tag),
        .alu_in        (alu_in),
        .mem_in        (mem_in),
        .br_in         (br_in),
        .commit_valid  (commit_valid),
        .commit_pd_old (commit_pd_old),
        .commit_pd_new (commit_pd_new),
        .commit_pc     (commit_pc),
        .commit_tag    (commit_tag),
        .rob_empty     (rob_empty),
        .head_tag      (head_tag)
`ifdef ROB_PERF_CNT_EN
        ,
        .perf_commits     (perf_commits),
        .perf_full_cycles (perf_full_cycles),
        .perf_flushes     (perf_flushes)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        disp_valid  = 1'b0;
        disp_pd_new = '0;
        disp_pd_old = '0;
        disp_pc     = '0;
        alu_in      = '0;
        mem_in      = '0;
        br_in       = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic dispatch(input logic [6:0] pn, input logic [6:0] po, input logic [31:0] pc);
        disp_valid  = 1'b1;
        disp_pd_new = pn;
        disp_pd_old = po;
        disp_pc     = pc;
        tick();
        disp_valid  = 1'b0;
    endtask

    // Instruction for slot t carries pd_new=t+80, pd_old=t+40, pc=4*t.
    task automatic dispatch_tag(input int t);
        dispatch(7'(t + 80), 7'(t + 40), 32'(t * 4));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
        n_cmp++; if (disp_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %0b want 1", disp_ready); end
        n_cmp++; if (rob_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty: got %0b want 1", rob_empty); end
        n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_commit_valid: got %0b want 0", commit_valid); end
        n_cmp++; if (commit_pd_old !== 7'd0) begin n_fail++; $display("[TB] FAIL reset_commit_pd_old: got %0d want 0", commit_pd_old); end
        n_cmp++; if (commit_pc !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_commit_pc: got %0h want 0", commit_pc); end
        n_cmp++; if (disp_tag !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_disp_tag: got %0d want 0", disp_tag); end
        n_cmp++; if (head_tag !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_head_tag: got %0d want 0", head_tag); end
    endtask

    task automatic test_dispatch();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (disp_tag !== 5'(i)) begin n_fail++; $display("[TB] FAIL dispatch_tag%0d: got %0d want %0d", i, disp_tag, i); end
            dispatch_tag(i);
        end
        n_cmp++; if (disp_tag !== 5'd3) begin n_fail++; $display("[TB] FAIL dispatch_tail: got %0d want 3", disp_tag); end
        n_cmp++; if (rob_empty !== 1'b0) begin n_fail++; $display("[TB] FAIL dispatch_empty: got %0b want 0", rob_empty); end
        n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL dispatch_no_commit: got %0b want 0", commit_valid); end
    endtask

    task automatic test_complete_commit();
        alu_in = '{fu_alu_done: 1'b1, rob_fu_alu: 5'd1};
        tick();
        clear_inputs();
        n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL head_incomplete: got %0b want 0", commit_valid); end
        mem_in = '{fu_mem_done: 1'b1, rob_fu_mem: 5'd0};
        tick();
        clear_inputs();
        n_cmp++; if (commit_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL commit0_valid: got %0b want 1", commit_valid); end
        n_cmp++; if (commit_tag !== 5'd0) begin n_fail++; $display("[TB] FAIL commit0_tag: got %0d want 0", commit_tag); end
        n_cmp++; if (commit_pd_old !== 7'd40) begin n_fail++; $display("[TB] FAIL commit0_pd_old: got %0d want 40", commit_pd_old); end
        n_cmp++; if (commit_pd_new !== 7'd80) begin n_fail++; $display("[TB] FAIL commit0_pd_new: got %0d want 80", commit_pd_new); end
        tick();
        n_cmp++; if (commit_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL commit1_valid: got %0b want 1", commit_valid); end
        n_cmp++; if (commit_tag !== 5'd1) begin n_fail++; $display("[TB] FAIL commit1_tag: got %0d want 1", commit_tag); end
        n_cmp++; if (commit_pd_old !== 7'd41) begin n_fail++; $display("[TB] FAIL commit1_pd_old: got %0d want 41", commit_pd_old); end
        n_cmp++; if (commit_pc !== 32'h4) begin n_fail++; $display("[TB] FAIL commit1_pc: got %0h want 4", commit_pc); end
        tick();
        n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL commit2_wait: got %0b want 0", commit_valid); end
        n_cmp++; if (head_tag !== 5'd2) begin n_fail++; $display("[TB] FAIL commit_head2: got %0d want 2", head_tag); end
    endtask

    task automatic test_min_latency();
        br_in = '{fu_b_done: 1'b1, rob_fu_b: 5'd2, mispredict: 1'b0, mispredict_tag: 5'd0};
        tick();
        clear_inputs();
        n_cmp++; if (commit_tag !== 5'd2 || commit_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL br_commit2: got v=%0b tag=%0d want v=1 tag=2", commit_valid, commit_tag); end
        tick();
        n_cmp++; if (rob_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL drained_empty: got %0b want 1", rob_empty); end
        dispatch_tag(3);
        n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL lat_n1: got %0b want 0", commit_valid); end
        alu_in = '{fu_alu_done: 1'b1, rob_fu_alu: 5'd3};
        tick();
        clear_inputs();
        n_cmp++; if (commit_valid !== 1'b1 || commit_tag !== 5'd3) begin n_fail++; $display("[TB] FAIL lat_n2: got v=%0b tag=%0d want v=1 tag=3", commit_valid, commit_tag); end
        tick();
        n_cmp++; if (head_tag !== 5'd4 || rob_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL lat_after: got head=%0d empty=%0b want head=4 empty=1", head_tag, rob_empty); end
    endtask

    task automatic test_full_wrap();
        clear_inputs();
        disp_valid = 1'b1;
        reset      = 1'b1;
        tick();
        reset      = 1'b0;
        disp_valid = 1'b0;
        n_cmp++; if (rob_empty !== 1'b1 || disp_tag !== 5'd0) begin n_fail++; $display("[TB] FAIL midreset: got empty=%0b tag=%0d want empty=1 tag=0", rob_empty, disp_tag); end
        for (int i = 0; i < 32; i++) dispatch_tag(i);
        n_cmp++; if (disp_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_ready: got %0b want 0", disp_ready); end
        n_cmp++; if (disp_tag !== 5'd0 || rob_empty !== 1'b0) begin n_fail++; $display("[TB] FAIL full_state: got tag=%0d empty=%0b want tag=0 empty=0", disp_tag, rob_empty); end
        alu_in = '{fu_alu_done: 1'b1, rob_fu_alu: 5'd0};
        tick();
        clear_inputs();
        n_cmp++; if (commit_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL full_commit_ready: got %0b want 1", commit_valid); end
        dispatch(7'd99, 7'd98, 32'h1000);
        n_cmp++; if (disp_tag !== 5'd0) begin n_fail++; $display("[TB] FAIL full_refused: got %0d want 0", disp_tag); end
        n_cmp++; if (disp_ready !== 1'b1 || head_tag !== 5'd1) begin n_fail++; $display("[TB] FAIL full_after_commit: got ready=%0b head=%0d want ready=1 head=1", disp_ready, head_tag); end
        dispatch(7'd99, 7'd98, 32'h1000);
        n_cmp++; if (disp_tag !== 5'd1 || disp_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_accept: got tag=%0d ready=%0b want tag=1 ready=0", disp_tag, disp_ready); end
        for (int k = 1; k <= 32; k++) begin
            alu_in = '{fu_alu_done: 1'b1, rob_fu_alu: 5'(k)};
            tick();
        end
        clear_inputs();
        n_cmp++; if (commit_valid !== 1'b1 || commit_tag !== 5'd0) begin n_fail++; $display("[TB] FAIL wrap_head: got v=%0b tag=%0d want v=1 tag=0", commit_valid, commit_tag); end
        n_cmp++; if (commit_pc !== 32'h1000 || commit_pd_old !== 7'd98) begin n_fail++; $display("[TB] FAIL wrap_payload: got pc=%0h pd_old=%0d want pc=1000 pd_old=98", commit_pc, commit_pd_old); end
        tick();
        n_cmp++; if (rob_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_empty: got %0b want 1", rob_empty); end
    endtask

    task automatic test_mispredict();
        do_reset();
        for (int i = 0; i < 10; i++) dispatch_tag(i);
        alu_in = '{fu_alu_done: 1'b1, rob_fu_alu: 5'd0};
        mem_in = '{fu_mem_done: 1'b1, rob_fu_mem: 5'd1};
        br_in  = '{fu_b_done: 1'b1, rob_fu_b: 5'd2, mispredict: 1'b0, mispredict_tag: 5'd0};
        tick();
        clear_inputs();
        alu_in = '{fu_alu_done: 1'b1, rob_fu_alu: 5'd3};
        tick();
        clear_inputs();
        repeat (3) tick();
        n_cmp++; if (head_tag !== 5'd4 || commit_valid !== 1'b0 || disp_tag !== 5'd10) begin n_fail++; $display("[TB] FAIL mp_setup: got head=%0d v=%0b tail=%0d want 4 0 10", head_tag, commit_valid, disp_tag); end
        br_in = '{fu_b_done: 1'b0, rob_fu_b: 5'd0, mispredict: 1'b1, mispredict_tag: 5'd6};
        tick();
        clear_inputs();
        n_cmp++; if (disp_tag !== 5'd7 || head_tag !== 5'd4) begin n_fail++; $display("[TB] FAIL mp_tail: got tail=%0d head=%0d want 7 4", disp_tag, head_tag); end
        alu_in = '{fu_alu_done: 1'b1, rob_fu_alu: 5'd8};
        mem_in = '{fu_mem_done: 1'b1, rob_fu_mem: 5'd5};
        br_in  = '{fu_b_done: 1'b1, rob_fu_b: 5'd4, mispredict: 1'b0, mispredict_tag: 5'd0};
        tick();
        clear_inputs();
        n_cmp++; if (commit_tag !== 5'd4 || commit_pd_old !== 7'd44) begin n_fail++; $display("[TB] FAIL mp_commit4: got tag=%0d pd_old=%0d want 4 44", commit_tag, commit_pd_old); end
        alu_in = '{fu_alu_done: 1'b1, rob_fu_alu: 5'd6};
        tick();
        clear_inputs();
        n_cmp++; if (commit_tag !== 5'd5 || commit_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mp_commit5: got tag=%0d v=%0b want 5 1", commit_tag, commit_valid); end
        tick();
        n_cmp++; if (commit_tag !== 5'd6 || commit_pc !== 32'h18) begin n_fail++; $display("[TB] FAIL mp_commit6: got tag=%0d pc=%0h want 6 18", commit_tag, commit_pc); end
        tick();
        n_cmp++; if (rob_empty !== 1'b1 || commit_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mp_count3: got empty=%0b v=%0b want 1 0", rob_empty, commit_valid); end
        n_cmp++; if (disp_tag !== 5'd7) begin n_fail++; $display("[TB] FAIL mp_next_tag: got %0d want 7", disp_tag); end
        dispatch_tag(7);
        n_cmp++; if (disp_tag !== 5'd8 || commit_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mp_redispatch: got tail=%0d v=%0b want 8 0", disp_tag, commit_valid); end
    endtask

    task automatic test_flush_commit();
        do_reset();
        for (int i = 0; i < 6; i++) dispatch_tag(i);
        alu_in = '{fu_alu_done: 1'b1, rob_fu_alu: 5'd0};
        mem_in = '{fu_mem_done: 1'b1, rob_fu_mem: 5'd1};
        br_in  = '{fu_b_done: 1'b1, rob_fu_b: 5'd2, mispredict: 1'b0, mispredict_tag: 5'd0};
        tick();
        clear_inputs();
        alu_in = '{fu_alu_done: 1'b1, rob_fu_alu: 5'd3};
        mem_in = '{fu_mem_done: 1'b1, rob_fu_mem: 5'd4};
        tick();
        clear_inputs();
        repeat (3) tick();
        n_cmp++; if (head_tag !== 5'd4 || commit_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL fc_setup: got head=%0d v=%0b want 4 1", head_tag, commit_valid); end
        br_in       = '{fu_b_done: 1'b0, rob_fu_b: 5'd0, mispredict: 1'b1, mispredict_tag: 5'd5};
        disp_valid  = 1'b1;
        disp_pc     = 32'h2000;
        disp_pd_old = 7'd77;
        tick();
        clear_inputs();
        n_cmp++; if (head_tag !== 5'd5 || disp_tag !== 5'd6) begin n_fail++; $display("[TB] FAIL fc_ptrs: got head=%0d tail=%0d want 5 6", head_tag, disp_tag); end
        n_cmp++; if (rob_empty !== 1'b0 || commit_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL fc_state: got empty=%0b v=%0b want 0 0", rob_empty, commit_valid); end
        br_in = '{fu_b_done: 1'b1, rob_fu_b: 5'd5, mispredict: 1'b0, mispredict_tag: 5'd0};
        tick();
        clear_inputs();
        n_cmp++; if (commit_tag !== 5'd5 || commit_pc !== 32'h14) begin n_fail++; $display("[TB] FAIL fc_branch_commit: got tag=%0d pc=%0h want 5 14", commit_tag, commit_pc); end
        tick();
        n_cmp++; if (rob_empty !== 1'b1 || disp_tag !== 5'd6) begin n_fail++; $display("[TB] FAIL fc_count1: got empty=%0b tail=%0d want 1 6", rob_empty, disp_tag); end
    endtask

`ifdef ROB_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        for (int i = 0; i < 12; i++) dispatch_tag(i);
        br_in = '{fu_b_done: 1'b0, rob_fu_b: 5'd0, mispredict: 1'b1, mispredict_tag: 5'd11};
        tick();
        tick();
        clear_inputs();
        for (int g = 0; g < 4; g++) begin
            alu_in = '{fu_alu_done: 1'b1, rob_fu_alu: 5'(3 * g)};
            mem_in = '{fu_mem_done: 1'b1, rob_fu_mem: 5'(3 * g + 1)};
            br_in  = '{fu_b_done: (g < 3), rob_fu_b: 5'(3 * g + 2), mispredict: 1'b0, mispredict_tag: 5'd0};
            if (g == 3) mem_in = '0;
            tick();
        end
        clear_inputs();
        repeat (12) tick();
        n_cmp++; if (perf_commits !== 32'd10) begin n_fail++; $display("[TB] FAIL perf_commits: got %0d want 10", perf_commits); end
        n_cmp++; if (perf_flushes !== 16'd2) begin n_fail++; $display("[TB] FAIL perf_flushes: got %0d want 2", perf_flushes); end
        n_cmp++; if (perf_full_cycles !== 32'd0) begin n_fail++; $display("[TB] FAIL perf_full: got %0d want 0", perf_full_cycles); end
        do_reset();
        n_cmp++; if (perf_commits !== 32'd0 || perf_flushes !== 16'd0) begin n_fail++; $display("[TB] FAIL perf_reset: got %0d %0d want 0 0", perf_commits, perf_flushes); end
    endtask
`endif

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_dispatch();
        test_complete_commit();
        test_min_latency();
        test_full_wrap();
        test_mispredict();
        test_flush_commit();
`ifdef ROB_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
